// File: rtl/snd_mixdac.sv
// N-channel volume/pan mixer feeding two first-order sigma-delta 1-bit DACs; one mix every SAMPLE_DIV cycles.
// Define MIXDAC_DITHER_EN to add LFSR dither (-2..+1 LSB) ahead of the integrators.
module snd_mixdac #(
  parameter int CHANNELS   = 4,
  parameter int IN_W       = 8,
  parameter int VOL_W      = 4,
  parameter int OUT_W      = 12,
  parameter int SHIFT      = 0,
  parameter int SAMPLE_DIV = 3500
) (
  input  logic                      clk168,
  input  logic                      rst_n,
  input  logic [CHANNELS*IN_W-1:0]  ch_data,
  input  logic [CHANNELS*VOL_W-1:0] ch_vol,
  input  logic [2*CHANNELS-1:0]     ch_pan,
  input  logic                      mono,
  input  logic                      clip_clr,
  output logic                      sample_valid,
  output logic [OUT_W-1:0]          sample_l,
  output logic [OUT_W-1:0]          sample_r,
  output logic                      clip_l,
  output logic                      clip_r,
  output logic                      dac_l,
  output logic                      dac_r
);

  localparam int CIW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW  = IN_W + VOL_W;
  localparam int AW  = PW + $clog2(CHANNELS) + 1;
  localparam int CW  = ((AW > OUT_W) ? AW : OUT_W) + 1;
  localparam int TW  = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] MAXC = {{(CW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, SNAP, ACCUM, OUT} state_t;
  state_t state, state_nxt;

  logic [TW-1:0]             cnt;
  logic                      tick, last;
  logic                      snap_en, acc_clr, acc_en, load;
  logic [CHANNELS*IN_W-1:0]  snap_data;
  logic [CHANNELS*VOL_W-1:0] snap_vol;
  logic [2*CHANNELS-1:0]     snap_pan;
  logic                      snap_mono;
  logic [CIW-1:0]            ch_idx;
  logic [AW-1:0]             acc_l, acc_r, acc_l_nxt, acc_r_nxt, mix_l, mix_r;
  logic [AW:0]               mono_sum;
  logic [IN_W-1:0]           cur_data;
  logic [VOL_W-1:0]          cur_vol;
  logic [PW-1:0]             prod;
  logic [OUT_W:0]            sat_l, sat_r;
  logic [OUT_W-1:0]          in_l, in_r;
  logic [OUT_W:0]            integ_l, integ_r;

  // Returns {clip, saturated sample}.
  function automatic logic [OUT_W:0] saturate(input logic [AW-1:0] v);
    logic [CW-1:0] e;
    e = CW'(v >> SHIFT);
    if (e > MAXC) return {1'b1, {OUT_W{1'b1}}};
    else          return {1'b0, e[OUT_W-1:0]};
  endfunction

  assign tick = (cnt == TW'(SAMPLE_DIV - 1));
  assign last = (ch_idx == CIW'(CHANNELS - 1));

  always_ff @(posedge clk168 or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk168 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A tick outside IDLE is simply dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick) state_nxt = SNAP;
      SNAP:    state_nxt = ACCUM;
      ACCUM:   if (last) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    snap_en      = 1'b0;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;
    load         = 1'b0;
    sample_valid = 1'b0;
    case (state)
      IDLE:    snap_en = tick;
      SNAP:    acc_clr = 1'b1;
      ACCUM:   begin acc_en = 1'b1; load = last; end
      OUT:     sample_valid = 1'b1;
      default: ;
    endcase
  end

  assign cur_data  = snap_data[ch_idx*IN_W +: IN_W];
  assign cur_vol   = snap_vol[ch_idx*VOL_W +: VOL_W];
  assign prod      = PW'(cur_data) * PW'(cur_vol);
  assign acc_l_nxt = acc_l + (snap_pan[2*ch_idx]   ? AW'(prod) : '0);
  assign acc_r_nxt = acc_r + (snap_pan[2*ch_idx+1] ? AW'(prod) : '0);
  assign mono_sum  = {1'b0, acc_l_nxt} + {1'b0, acc_r_nxt};
  assign mix_l     = snap_mono ? AW'(mono_sum >> 1) : acc_l_nxt;
  assign mix_r     = snap_mono ? AW'(mono_sum >> 1) : acc_r_nxt;
  assign sat_l     = saturate(mix_l);
  assign sat_r     = saturate(mix_r);

  always_ff @(posedge clk168 or negedge rst_n) begin
    if (!rst_n) begin
      snap_data <= '0;
      snap_vol  <= '0;
      snap_pan  <= '0;
      snap_mono <= 1'b0;
      ch_idx    <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
    end else begin
      if (snap_en) begin
        snap_data <= ch_data;
        snap_vol  <= ch_vol;
        snap_pan  <= ch_pan;
        snap_mono <= mono;
      end
      if (acc_clr) begin
        ch_idx <= '0;
        acc_l  <= '0;
        acc_r  <= '0;
      end else if (acc_en) begin
        ch_idx <= ch_idx + 1'b1;
        acc_l  <= acc_l_nxt;
        acc_r  <= acc_r_nxt;
      end
    end
  end

  // Samples load on the last accumulate edge so they are stable while sample_valid is high.
  always_ff @(posedge clk168 or negedge rst_n) begin
    if (!rst_n) begin
      sample_l <= '0;
      sample_r <= '0;
      clip_l   <= 1'b0;
      clip_r   <= 1'b0;
    end else begin
      if (load) begin
        sample_l <= sat_l[OUT_W-1:0];
        sample_r <= sat_r[OUT_W-1:0];
      end
      clip_l <= (load & sat_l[OUT_W]) | (clip_l & ~clip_clr);
      clip_r <= (load & sat_r[OUT_W]) | (clip_r & ~clip_clr);
    end
  end

`ifdef MIXDAC_DITHER_EN
  logic [15:0]    lfsr;
  logic [OUT_W+1:0] dsum_l, dsum_r, dith;

  always_ff @(posedge clk168 or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Two's-complement add of the sign-extended dither; top bit flags underflow, next bit overflow.
  assign dith   = {{OUT_W{lfsr[1]}}, lfsr[1:0]};
  assign dsum_l = {2'b00, sample_l} + dith;
  assign dsum_r = {2'b00, sample_r} + dith;
  assign in_l   = dsum_l[OUT_W+1] ? '0 : (dsum_l[OUT_W] ? {OUT_W{1'b1}} : dsum_l[OUT_W-1:0]);
  assign in_r   = dsum_r[OUT_W+1] ? '0 : (dsum_r[OUT_W] ? {OUT_W{1'b1}} : dsum_r[OUT_W-1:0]);
`else
  assign in_l = sample_l;
  assign in_r = sample_r;
`endif

  always_ff @(posedge clk168 or negedge rst_n) begin
    if (!rst_n) begin
      integ_l <= '0;
      integ_r <= '0;
    end else begin
      integ_l <= {1'b0, integ_l[OUT_W-1:0]} + {1'b0, in_l};
      integ_r <= {1'b0, integ_r[OUT_W-1:0]} + {1'b0, in_r};
    end
  end

  assign dac_l = integ_l[OUT_W];
  assign dac_r = integ_r[OUT_W];

endmodule

// File: tb/tb_snd_mixdac.sv
// Directed bench for snd_mixdac at default parameters (4 channels, 12-bit DAC, 3500-cycle sample period).
module tb_snd_mixdac;
  logic        clk168 = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ch_data = '0;
  logic [15:0] ch_vol = '0;
  logic [7:0]  ch_pan = '0;
  logic        mono = 1'b0;
  logic        clip_clr = 1'b0;
  logic        sample_valid;
  logic [11:0] sample_l, sample_r;
  logic        clip_l, clip_r, dac_l, dac_r;

  int checks = 0;
  int passes = 0;

  snd_mixdac dut (
    .clk168(clk168), .rst_n(rst_n), .ch_data(ch_data), .ch_vol(ch_vol), .ch_pan(ch_pan),
    .mono(mono), .clip_clr(clip_clr), .sample_valid(sample_valid), .sample_l(sample_l),
    .sample_r(sample_r), .clip_l(clip_l), .clip_r(clip_r), .dac_l(dac_l), .dac_r(dac_r)
  );

  always #3 clk168 = ~clk168;

  // Advances negedge by negedge until sample_valid; n > 8000 means it never came.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk168);
      n++;
    end while (!sample_valid && n <= 8000);
  endtask

  task automatic set_basic();
    ch_data = 32'h0000_0080;
    ch_vol  = 16'h000F;
    ch_pan  = 8'b0000_0001;
    mono    = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    set_basic();
    repeat (3) @(negedge clk168);
    checks++; if (sample_valid !== 1'b0) $display("FAIL rst_valid: got %0d expected 0", sample_valid); else passes++;
    checks++; if (sample_l !== 12'd0) $display("FAIL rst_sample_l: got %0d expected 0", sample_l); else passes++;
    checks++; if ({clip_l, clip_r, dac_l, dac_r} !== 4'b0) $display("FAIL rst_flags: got %b expected 0000", {clip_l, clip_r, dac_l, dac_r}); else passes++;
    rst_n = 1'b1;
    wait_valid(n);
    checks++; if (n !== 3505) $display("FAIL first_latency: got %0d expected 3505", n); else passes++;
    checks++; if (sample_l !== 12'd1920) $display("FAIL first_sample_l: got %0d expected 1920", sample_l); else passes++;
    checks++; if (sample_r !== 12'd0) $display("FAIL first_sample_r: got %0d expected 0", sample_r); else passes++;
  endtask

  task automatic test_basic();
    int n, hl, hr;
    wait_valid(n);
    checks++; if (n !== 3500) $display("FAIL period: got %0d expected 3500", n); else passes++;
    checks++; if (sample_l !== 12'd1920) $display("FAIL basic_sample_l: got %0d expected 1920", sample_l); else passes++;
    hl = 0; hr = 0;
    repeat (4096) begin
      @(negedge clk168);
      hl += int'(dac_l);
      hr += int'(dac_r);
    end
    checks++; if (hl !== 1920) $display("FAIL basic_density_l: got %0d expected 1920", hl); else passes++;
    checks++; if (hr !== 0) $display("FAIL basic_density_r: got %0d expected 0", hr); else passes++;
  endtask

  task automatic test_mono();
    int n, hl, hr;
    wait_valid(n);
    mono = 1'b1;
    wait_valid(n);
    checks++; if (n !== 3500) $display("FAIL mono_period: got %0d expected 3500", n); else passes++;
    checks++; if (sample_l !== 12'd960 || sample_r !== 12'd960)
      $display("FAIL mono_samples: got %0d/%0d expected 960/960", sample_l, sample_r); else passes++;
    hl = 0; hr = 0;
    repeat (4096) begin
      @(negedge clk168);
      hl += int'(dac_l);
      hr += int'(dac_r);
    end
    checks++; if (hl !== 960) $display("FAIL mono_density_l: got %0d expected 960", hl); else passes++;
    checks++; if (hr !== 960) $display("FAIL mono_density_r: got %0d expected 960", hr); else passes++;
    mono = 1'b0;
  endtask

  task automatic test_clip();
    int n;
    wait_valid(n);
    ch_data = 32'hFFFF_FFFF;
    ch_vol  = 16'hFFFF;
    ch_pan  = 8'hFF;
    wait_valid(n);
    checks++; if (sample_l !== 12'd4095 || sample_r !== 12'd4095)
      $display("FAIL clip_samples: got %0d/%0d expected 4095/4095", sample_l, sample_r); else passes++;
    checks++; if ({clip_l, clip_r} !== 2'b11) $display("FAIL clip_set: got %b expected 11", {clip_l, clip_r}); else passes++;
    ch_data = 32'h0;
    wait_valid(n);
    checks++; if (sample_l !== 12'd0) $display("FAIL clip_zero_sample: got %0d expected 0", sample_l); else passes++;
    checks++; if ({clip_l, clip_r} !== 2'b11) $display("FAIL clip_sticky: got %b expected 11", {clip_l, clip_r}); else passes++;
    clip_clr = 1'b1;
    @(negedge clk168);
    clip_clr = 1'b0;
    checks++; if ({clip_l, clip_r} !== 2'b00) $display("FAIL clip_cleared: got %b expected 00", {clip_l, clip_r}); else passes++;
    // Clear held across a saturating load: the set must win on that edge.
    ch_data  = 32'hFFFF_FFFF;
    clip_clr = 1'b1;
    wait_valid(n);
    checks++; if ({clip_l, clip_r} !== 2'b11) $display("FAIL clip_set_wins: got %b expected 11", {clip_l, clip_r}); else passes++;
    @(negedge clk168);
    checks++; if ({clip_l, clip_r} !== 2'b00) $display("FAIL clip_clr_after: got %b expected 00", {clip_l, clip_r}); else passes++;
    clip_clr = 1'b0;
  endtask

  task automatic test_change_after_tick();
    int n;
    set_basic();
    wait_valid(n);
    checks++; if (sample_l !== 12'd1920) $display("FAIL pre_change: got %0d expected 1920", sample_l); else passes++;
    repeat (3495) @(negedge clk168);
    ch_data = 32'h0;
    wait_valid(n);
    checks++; if (n !== 5) $display("FAIL change_latency: got %0d expected 5", n); else passes++;
    checks++; if (sample_l !== 12'd1920) $display("FAIL snap_held: got %0d expected 1920", sample_l); else passes++;
    wait_valid(n);
    checks++; if (sample_l !== 12'd0) $display("FAIL next_zero: got %0d expected 0", sample_l); else passes++;
  endtask

  task automatic test_reset_mid();
    int n, nv;
    set_basic();
    wait_valid(n);
    wait_valid(n);
    checks++; if (sample_l !== 12'd1920) $display("FAIL pre_reset: got %0d expected 1920", sample_l); else passes++;
    repeat (3497) @(negedge clk168);
    rst_n = 1'b0;
    #1;
    checks++; if (sample_l !== 12'd0 || sample_r !== 12'd0)
      $display("FAIL mid_rst_samples: got %0d/%0d expected 0/0", sample_l, sample_r); else passes++;
    checks++; if ({sample_valid, clip_l, clip_r, dac_l, dac_r} !== 5'b0)
      $display("FAIL mid_rst_flags: got %b expected 00000", {sample_valid, clip_l, clip_r, dac_l, dac_r}); else passes++;
    repeat (2) @(negedge clk168);
    rst_n = 1'b1;
    nv = 0;
    repeat (3500) begin
      @(negedge clk168);
      if (sample_valid) nv++;
    end
    checks++; if (nv !== 0) $display("FAIL post_rst_quiet: got %0d pulses expected 0", nv); else passes++;
    wait_valid(n);
    checks++; if (n !== 5) $display("FAIL post_rst_latency: got %0d expected 5", n); else passes++;
    checks++; if (sample_l !== 12'd1920) $display("FAIL post_rst_sample: got %0d expected 1920", sample_l); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mono();
    test_clip();
    test_change_after_tick();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
